// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge: CPU writes to OUT_ADDR feed a TX FIFO that streams
// to the host; host stream words land in an RX FIFO popped by CPU reads of IN_ADDR.
module mmio_io_bridge #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned IN_ADDR    = 24576,
    parameter int unsigned OUT_ADDR   = 24577,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic signed [DATA_WIDTH-1:0]  data,
    input  logic                          we,
    input  logic                          re,
    output logic signed [DATA_WIDTH-1:0]  inputWire,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(DEPTH):0]        out_count,
    output logic [$clog2(DEPTH):0]        in_count,
    output logic                          out_overflow,
    output logic                          in_underflow,
    input  logic                          clr_flags
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [DEPTH];

    logic [PW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_req, tx_push, tx_pop, tx_overflow_set;
    logic rx_pop_req, rx_push, rx_pop, rx_underflow_set;

    // Handshake decode; a pop frees the slot a full-FIFO push needs in the same cycle.
    always_comb begin
        tx_empty         = (tx_count_q == '0);
        tx_full          = (tx_count_q == FULL_COUNT);
        rx_empty         = (rx_count_q == '0);
        rx_full          = (rx_count_q == FULL_COUNT);

        tx_push_req      = we && (addr == ADDR_WIDTH'(OUT_ADDR));
        tx_pop           = !tx_empty && out_ready;
        tx_push          = tx_push_req && (!tx_full || tx_pop);
        tx_overflow_set  = tx_push_req && tx_full && !tx_pop;

        rx_pop_req       = re && (addr == ADDR_WIDTH'(IN_ADDR));
        rx_push          = in_valid && !rx_full;
        rx_pop           = rx_pop_req && !rx_empty;
        rx_underflow_set = rx_pop_req && rx_empty;
    end

    // Next-state occupancy and sticky flags; a same-cycle set beats clr_flags.
    always_comb begin
        tx_count_d = tx_count_q;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count_q + 1'b1;
        end else if (tx_pop && !tx_push) begin
            tx_count_d = tx_count_q - 1'b1;
        end

        rx_count_d = rx_count_q;
        if (rx_push && !rx_pop) begin
            rx_count_d = rx_count_q + 1'b1;
        end else if (rx_pop && !rx_push) begin
            rx_count_d = rx_count_q - 1'b1;
        end

        overflow_d = overflow_q;
        if (tx_overflow_set) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (rx_underflow_set) begin
            underflow_d = 1'b1;
        end else if (clr_flags) begin
            underflow_d = 1'b0;
        end
    end

    // Pointers, counts and flags; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_count_q  <= '0;
            rx_count_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage arrays; stale contents are masked by the counts, so no reset is needed.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= data;
        if (rx_push) rx_mem[rx_wptr_q] <= in_data;
    end

    // First-word fall-through outputs, forced to zero whenever the FIFO is empty.
    always_comb begin
        out_valid    = !tx_empty;
        out_data     = tx_empty ? '0 : tx_mem[tx_rptr_q];
        in_ready     = !rx_full;
        inputWire    = rx_empty ? '0 : rx_mem[rx_rptr_q];
        out_count    = tx_count_q;
        in_count     = rx_count_q;
        out_overflow = overflow_q;
        in_underflow = underflow_q;
    end

endmodule

// File: doc/mmio_io_bridge.md
MMIO_IO_BRIDGE -- requirements
Module: mmio_io_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning CPU data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning CPU address width.
REQ-003 SHALL have parameter IN_ADDR, default 24576, meaning the memory-mapped input-port address.
REQ-004 SHALL have parameter OUT_ADDR, default 24577, meaning the memory-mapped output-port address.
REQ-005 SHALL have parameter DEPTH, default 4, a power of 2 >= 2, meaning entries per FIFO.
REQ-006 SHALL use one clock, clk; reset is asynchronous and active-low.
REQ-007 SHALL have ports: clk in 1, the single clock (rising edge).
REQ-008 SHALL have ports: reset in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: addr in ADDR_WIDTH, the CPU address.
REQ-010 SHALL have ports: data in DATA_WIDTH signed, the CPU write data.
REQ-011 SHALL have ports: we in 1, CPU write strobe; re in 1, CPU read strobe.
REQ-012 SHALL have ports: inputWire out DATA_WIDTH signed, the input-port value returned to memory.
REQ-013 SHALL have ports: out_data out DATA_WIDTH, out_valid out 1, out_ready in 1, the host-bound stream.
REQ-014 SHALL have ports: in_data in DATA_WIDTH, in_valid in 1, in_ready out 1, the host-sourced stream.
REQ-015 SHALL have ports: out_count out $clog2(DEPTH)+1 and in_count out $clog2(DEPTH)+1, the FIFO occupancies.
REQ-016 SHALL have ports: out_overflow out 1 and in_underflow out 1 (sticky flags), plus clr_flags in 1.

Function
REQ-017 SHALL contain a TX FIFO and an RX FIFO, each DEPTH entries, with read/write pointers wrapping modulo DEPTH; full is count==DEPTH and empty is count==0.
REQ-018 SHALL push data into TX at a rising edge when we=1, addr==OUT_ADDR, and TX is not full.
REQ-019 SHALL leave TX unchanged and set out_overflow on a TX push attempt while full with no same-cycle pop.
REQ-020 SHALL drive out_valid=(TX count!=0) and out_data=TX head (first-word fall-through), so a pushed word is visible one cycle after its push edge.
REQ-021 SHALL pop TX at an edge where out_valid&&out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 SHALL accept simultaneous TX push and pop when full: both occur, count is unchanged, and no overflow is flagged.
REQ-023 SHALL drive in_ready=(RX count!=DEPTH) and push in_data into RX at an edge where in_valid&&in_ready.
REQ-024 SHALL drive inputWire combinationally as the RX head when RX is non-empty, else 0.
REQ-025 SHALL pop RX at an edge where re=1, addr==IN_ADDR, and RX is non-empty.
REQ-026 SHALL not pop on an RX read attempt while empty, SHALL set in_underflow, and inputWire SHALL read 0.
REQ-027 SHALL allow simultaneous RX push and pop when non-empty, leaving count unchanged; when RX is empty, a same-cycle push SHALL succeed and the read SHALL count as underflow.
REQ-028 SHALL ignore we at addresses other than OUT_ADDR and re at addresses other than IN_ADDR; we at IN_ADDR and re at OUT_ADDR have no effect.
REQ-029 SHALL clear both sticky flags on clr_flags=1 at an edge; a same-cycle set SHALL take priority over the clear.
REQ-030 SHALL make out_count and in_count registered, exact, never exceeding DEPTH, and never wrapping.
REQ-031 SHALL pass data bits unmodified, with no sign handling.

Reset
REQ-032 SHALL, while reset=0, asynchronously force: pointers and counts to 0, out_valid=0, out_data=0, in_ready=1, inputWire=0, and out_overflow=in_underflow=0.
REQ-033 SHALL discard all FIFO contents on reset asserted mid-transfer; no partial word SHALL survive.
REQ-034 SHALL honour the first push or pop at the first rising edge after reset deasserts.

Verification
REQ-035 Scenario: we=1, addr=24577, data=16'h1234, with out_ready=0 -> next cycle out_valid=1, out_data=16'h1234, out_count=1; then out_ready=1 -> pop and out_valid=0.
REQ-036 Scenario: 5 writes to 24577 with DEPTH=4 and out_ready=0 -> out_count=4, out_overflow=1, and drained order is the first 4 words.
REQ-037 Scenario: host pushes 16'hFFFE then 16'h0007 -> inputWire=16'hFFFE; re=1, addr=24576 -> inputWire=16'h0007 and in_count=1.
REQ-038 Scenario: re=1, addr=24576 with RX empty -> inputWire=0, in_underflow=1; then clr_flags=1 -> in_underflow=0.
REQ-039 Scenario: TX full with write to 24577 and out_ready=1 in the same cycle -> count stays 4, no overflow, and the new word is last in drain order.
REQ-040 Scenario: reset=0 pulsed mid-stream with both FIFOs holding 2 words -> counts=0, out_valid=0, and in_ready=1 immediately (asynchronous).
